conv2d_stream_kxk: RTL and testbench

- Streaming single-channel 2-D convolution engine; successor to the fixed 9x9 / 96-wide / hard-coded-kernel conv stage.
- Kernel size, image geometry, data width and fixed-point scaling are parameters; coefficients and bias are runtime-loadable.
- Emits only valid (fully-inside) window results with a valid strobe. Fixed pipeline latency; no row-wrap garbage.
- Sits between the pixel feeder (upstream) and the pooling/save stage (downstream) of each CNN layer.

---
 rtl/conv_pkg.sv | 36 +++
 rtl/conv2d_stream_kxk_if.sv | 29 ++
 rtl/conv_line_buffer.sv | 54 +++++
 rtl/conv2d_stream_kxk.sv | 139 +++++++++++++
 tb/tb_conv2d_stream_kxk.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared FSM state type, pipeline depth and fixed-point helpers for the KxK convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } conv_state_t;

  // window register -> products -> adder tree -> round/bias/saturate
  localparam int PIPE_LAT = 4;

  function automatic int acc_width(input int data_w, input int k);
    return 2 * data_w + $clog2(k * k);
  endfunction

  // Round half up, drop frac bits, add bias in output units, clamp to a signed dw-bit range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input logic signed [63:0] bias,
                                                   input int frac,
                                                   input int dw);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = acc;
    if (frac > 0) r = (r + (64'sd1 <<< (frac - 1))) >>> frac;
    r  = r + bias;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/conv2d_stream_kxk_if.sv
// Pixel-in / map-out stream, coefficient load port and frame status of the KxK convolution engine.
interface conv2d_stream_kxk_if #(
  parameter int DATA_W = 16,
  parameter int K      = 3
);
  localparam int AW = $clog2(K * K + 1);

  logic                     start;
  logic signed [DATA_W-1:0] pix_in;
  logic                     pix_valid;
  logic                     pix_ready;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [DATA_W-1:0] coef_data;
  logic signed [DATA_W-1:0] map_out;
  logic                     out_valid;
  logic                     busy;
  logic                     done;

  modport master (
    output start, pix_in, pix_valid, coef_we, coef_addr, coef_data,
    input  pix_ready, map_out, out_valid, busy, done
  );

  modport slave (
    input  start, pix_in, pix_valid, coef_we, coef_addr, coef_data,
    output pix_ready, map_out, out_valid, busy, done
  );
endinterface

// File: rtl/conv_line_buffer.sv
// K-1 full-row delay lines feeding a KxK sliding window; everything advances only when shift_en is high.
module conv_line_buffer #(
  parameter int DATA_W = 16,
  parameter int K      = 3,
  parameter int IMG_W  = 28
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic                     shift_en,
  input  logic signed [DATA_W-1:0] pix_in,
  output logic signed [DATA_W-1:0] win [K*K]
);

  // col_in[r] is the newest column entering window row r; row K-1 is the current image row.
  logic signed [DATA_W-1:0] col_in  [K];
  logic signed [DATA_W-1:0] win_reg [K][K];

  assign col_in[K-1] = pix_in;

  genvar gi;
  generate
    for (gi = 0; gi < K - 1; gi++) begin : g_line
      logic signed [DATA_W-1:0] taps_reg [IMG_W];

      always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < IMG_W; j++) taps_reg[j] <= '0;
        end else if (shift_en) begin
          taps_reg[0] <= col_in[K-1-gi];
          for (int j = 1; j < IMG_W; j++) taps_reg[j] <= taps_reg[j-1];
        end
      end

      assign col_in[K-2-gi] = taps_reg[IMG_W-1];
    end

    for (gi = 0; gi < K * K; gi++) begin : g_flat
      assign win[gi] = win_reg[gi / K][gi % K];
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win_reg[r][c] <= '0;
    end else if (shift_en) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_reg[r][c] <= win_reg[r][c+1];
        win_reg[r][K-1] <= col_in[r];
      end
    end
  end

endmodule

// File: rtl/conv2d_stream_kxk.sv
// Streaming single-channel KxK convolution: line-buffer window, products, adder tree, round/bias/saturate.
// Build option CONV_RELU_EN: negative saturated results are forced to zero (latency unchanged).
module conv2d_stream_kxk
  import conv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int K      = 3,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int FRAC   = 12
) (
  input logic                clk_in,
  input logic                rst_n,
  conv2d_stream_kxk_if.slave bus
);

  localparam int ACC_W = acc_width(DATA_W, K);
  localparam int NTAP  = K * K;
  localparam int AW    = $clog2(NTAP + 1);
  localparam int CW    = $clog2(IMG_W + 1);
  localparam int RW    = $clog2(IMG_H + 1);
  localparam int PW    = 2 * DATA_W;

  conv_state_t              state_reg, state_next;
  logic [CW-1:0]            col_reg;
  logic [RW-1:0]            row_reg;
  logic [PIPE_LAT-1:0]      vld_reg;
  logic signed [DATA_W-1:0] coef_reg [NTAP];
  logic signed [DATA_W-1:0] bias_reg;
  logic signed [DATA_W-1:0] win      [NTAP];
  logic signed [PW-1:0]     prod_reg [NTAP];
  logic signed [ACC_W-1:0]  sum_reg, sum_next;
  logic signed [DATA_W-1:0] map_reg, map_next;
  logic                     pix_ready, frame_busy, frame_done;
  logic                     accept, last_pix, win_hit;

  assign accept   = bus.pix_valid & pix_ready;
  assign last_pix = (col_reg == CW'(IMG_W - 1)) && (row_reg == RW'(IMG_H - 1));
  assign win_hit  = accept && (row_reg >= RW'(K - 1)) && (col_reg >= CW'(K - 1));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // DRAIN ends once nothing is in flight ahead of the output register.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (accept && last_pix) state_next = DRAIN;
      DRAIN:   if (~|vld_reg[PIPE_LAT-2:0]) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pix_ready  = (state_reg == RUN);
    frame_busy = (state_reg != IDLE);
    frame_done = (state_reg == DONE);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (state_reg == IDLE && bus.start) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (accept) begin
      if (col_reg == CW'(IMG_W - 1)) begin
        col_reg <= '0;
        row_reg <= last_pix ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  // Coefficients are frozen for the whole frame; addresses past the bias slot fall through.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAP; i++) coef_reg[i] <= '0;
      bias_reg <= '0;
    end else if (bus.coef_we && state_reg == IDLE) begin
      for (int i = 0; i < NTAP; i++)
        if (bus.coef_addr == AW'(i)) coef_reg[i] <= bus.coef_data;
      if (bus.coef_addr == AW'(NTAP)) bias_reg <= bus.coef_data;
    end
  end

  conv_line_buffer #(
    .DATA_W (DATA_W),
    .K      (K),
    .IMG_W  (IMG_W)
  ) u_line_buffer (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .shift_en (accept),
    .pix_in   (bus.pix_in),
    .win      (win)
  );

  always_comb begin
    sum_next = '0;
    for (int i = 0; i < NTAP; i++) sum_next = sum_next + ACC_W'(prod_reg[i]);
  end

  always_comb begin
    map_next = DATA_W'(round_sat(64'(sum_reg), 64'(bias_reg), FRAC, DATA_W));
`ifdef CONV_RELU_EN
    if (map_next[DATA_W-1]) map_next = '0;
`endif
  end

  // vld_reg[0]: window, [1]: products, [2]: sum, [3]: output register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      vld_reg <= '0;
      for (int i = 0; i < NTAP; i++) prod_reg[i] <= '0;
      sum_reg <= '0;
      map_reg <= '0;
    end else begin
      vld_reg <= {vld_reg[PIPE_LAT-2:0], win_hit};
      if (vld_reg[0])
        for (int i = 0; i < NTAP; i++) prod_reg[i] <= PW'(win[i]) * PW'(coef_reg[i]);
      if (vld_reg[1]) sum_reg <= sum_next;
      if (vld_reg[2]) map_reg <= map_next;
    end
  end

  assign bus.pix_ready = pix_ready;
  assign bus.busy      = frame_busy;
  assign bus.done      = frame_done;
  assign bus.map_out   = map_reg;
  assign bus.out_valid = vld_reg[PIPE_LAT-1];

endmodule

// File: tb/tb_conv2d_stream_kxk.sv
// Directed bench: two engines (FRAC=0 and FRAC=12) on a 5x5 image with a 3x3 kernel, shared stimulus.
module tb_conv2d_stream_kxk;

  localparam int DATA_W = 16;
  localparam int K      = 3;
  localparam int IMG_W  = 5;
  localparam int IMG_H  = 5;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NOUT   = (IMG_W - K + 1) * (IMG_H - K + 1);

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  logic                     start_s     = 1'b0;
  logic                     pix_valid_s = 1'b0;
  logic                     coef_we_s   = 1'b0;
  logic signed [DATA_W-1:0] pix_s       = '0;
  logic signed [DATA_W-1:0] coef_data_s = '0;
  logic [3:0]               coef_addr_s = '0;

  conv2d_stream_kxk_if #(.DATA_W(DATA_W), .K(K)) if_a ();
  conv2d_stream_kxk_if #(.DATA_W(DATA_W), .K(K)) if_b ();

  assign if_a.start     = start_s;
  assign if_a.pix_in    = pix_s;
  assign if_a.pix_valid = pix_valid_s;
  assign if_a.coef_we   = coef_we_s;
  assign if_a.coef_addr = coef_addr_s;
  assign if_a.coef_data = coef_data_s;
  assign if_b.start     = start_s;
  assign if_b.pix_in    = pix_s;
  assign if_b.pix_valid = pix_valid_s;
  assign if_b.coef_we   = coef_we_s;
  assign if_b.coef_addr = coef_addr_s;
  assign if_b.coef_data = coef_data_s;

  conv2d_stream_kxk #(.DATA_W(DATA_W), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H), .FRAC(0)) dut_a (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (if_a)
  );

  conv2d_stream_kxk #(.DATA_W(DATA_W), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H), .FRAC(12)) dut_b (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (if_b)
  );

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  logic signed [31:0] qa[$];
  logic signed [31:0] qb[$];
  int oc_q[$];
  int acc_q[$];
  int done_total = 0;
  int done_cyc   = 0;

  always @(negedge clk_in) begin
    if (if_a.out_valid) begin
      qa.push_back(32'(if_a.map_out));
      oc_q.push_back(cyc);
    end
    if (if_b.out_valid) qb.push_back(32'(if_b.map_out));
    if (if_a.pix_valid && if_a.pix_ready) acc_q.push_back(cyc);
    if (if_a.done) begin
      done_total <= done_total + 1;
      done_cyc   <= cyc;
    end
  end

  int total = 0;
  int bad   = 0;
  logic signed [DATA_W-1:0] pix_mem [NPIX];
  logic signed [31:0]       exp_v   [NOUT];
  int ba, bb, bacc, bdone;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < NPIX; i++) pix_mem[i] = 16'(v);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NPIX; i++) pix_mem[i] = 16'(i);
  endtask

  task automatic exp_const(input int v);
    for (int i = 0; i < NOUT; i++) exp_v[i] = v;
  endtask

  // Centre tap only on a raster ramp: output is the pixel at the window centre.
  task automatic exp_ramp_centre();
    for (int r = 0; r < IMG_H - K + 1; r++)
      for (int c = 0; c < IMG_W - K + 1; c++)
        exp_v[r * (IMG_W - K + 1) + c] = (r + 1) * IMG_W + (c + 1);
  endtask

  task automatic load_kernel(input int centre, input int other, input int bias);
    for (int i = 0; i < K * K; i++) begin
      coef_we_s   = 1'b1;
      coef_addr_s = 4'(i);
      coef_data_s = 16'((i == (K * K) / 2) ? centre : other);
      tick();
    end
    coef_addr_s = 4'(K * K);
    coef_data_s = 16'(bias);
    tick();
    coef_we_s = 1'b0;
  endtask

  task automatic run_frame(input bit gap, input bit busy_wr);
    ba    = qa.size();
    bb    = qb.size();
    bacc  = acc_q.size();
    bdone = done_total;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      pix_s       = pix_mem[i];
      pix_valid_s = 1'b1;
      coef_we_s   = busy_wr && (i == 3 || i == 4);
      coef_addr_s = (i == 3) ? 4'd4 : 4'd9;
      coef_data_s = (i == 3) ? 16'sd7 : 16'sd100;
      tick();
      coef_we_s = 1'b0;
      if (gap) begin
        pix_valid_s = 1'b0;
        tick();
      end
    end
    pix_valid_s = 1'b0;
    for (int t = 0; t < 40 && done_total == bdone; t++) tick();
    tick();
  endtask

  task automatic check_frame(input string tag, input bit use_b);
    int n;
    logic signed [31:0] v;
    n = use_b ? (qb.size() - bb) : (qa.size() - ba);
    chk({tag, "_count"}, n, NOUT);
    for (int i = 0; i < NOUT; i++) begin
      if (i < n) v = use_b ? qb[bb + i] : qa[ba + i];
      else       v = 32'sh7fff_ffff;
      chk($sformatf("%s_out%0d", tag, i), v, exp_v[i]);
    end
    chk({tag, "_done"}, done_total - bdone, 1);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_map_out",   if_a.map_out,   0);
    chk("rst_out_valid", if_a.out_valid, 0);
    chk("rst_pix_ready", if_a.pix_ready, 0);
    chk("rst_busy",      if_a.busy,      0);
    chk("rst_done",      if_a.done,      0);
    rst_n = 1'b1;
    tick();

    // all-ones image and kernel: every window sums to 9
    load_kernel(1, 1, 0);
    fill_const(1);
    exp_const(9);
    run_frame(1'b0, 1'b0);
    check_frame("t1", 1'b0);
    chk("t1_latency",  oc_q[ba] - acc_q[bacc + 12], 4);
    chk("t1_done_gap", done_cyc - oc_q[ba + NOUT - 1], 1);

    load_kernel(1, 0, 0);
    fill_ramp();
    exp_ramp_centre();
    run_frame(1'b0, 1'b0);
    check_frame("t2", 1'b0);

    // FRAC=12 engine: 9 * 30000 in output units saturates both ways
    load_kernel(4096, 4096, 0);
    fill_const(30000);
    exp_const(32767);
    run_frame(1'b0, 1'b0);
    check_frame("t3_pos", 1'b1);
    load_kernel(-4096, -4096, 0);
`ifdef CONV_RELU_EN
    exp_const(0);
`else
    exp_const(-32768);
`endif
    run_frame(1'b0, 1'b0);
    check_frame("t3_neg", 1'b1);

    // half-LSB rounding: 2048/4096 of a pixel
    load_kernel(2048, 0, 0);
    fill_const(1);
    exp_const(1);
    run_frame(1'b0, 1'b0);
    check_frame("t4_half_pos", 1'b1);
    fill_const(-1);
    exp_const(0);
    run_frame(1'b0, 1'b0);
    check_frame("t4_half_neg", 1'b1);
    load_kernel(2048, 0, 5);
    fill_const(1);
    exp_const(6);
    run_frame(1'b0, 1'b0);
    check_frame("t4_bias_pos", 1'b1);
    fill_const(-1);
    exp_const(5);
    run_frame(1'b0, 1'b0);
    check_frame("t4_bias_neg", 1'b1);

    // pixels offered while idle must be ignored; then a frame with alternate-cycle bubbles
    load_kernel(1, 0, 0);
    fill_ramp();
    exp_ramp_centre();
    pix_s       = 16'sd999;
    pix_valid_s = 1'b1;
    repeat (3) tick();
    chk("t5_idle_ready", if_a.pix_ready, 0);
    pix_valid_s = 1'b0;
    run_frame(1'b1, 1'b0);
    check_frame("t5_gap", 1'b0);

    // abort a frame with reset after 10 pixels
    bdone   = done_total;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pix_s       = pix_mem[i];
      pix_valid_s = 1'b1;
      tick();
    end
    chk("t6_busy_before", if_a.busy,    1);
    chk("t6_map_before",  if_a.map_out, 18);
    rst_n       = 1'b0;
    pix_valid_s = 1'b0;
    #1;
    chk("t6_rst_map_out",   if_a.map_out,   0);
    chk("t6_rst_out_valid", if_a.out_valid, 0);
    chk("t6_rst_busy",      if_a.busy,      0);
    chk("t6_rst_pix_ready", if_a.pix_ready, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("t6_no_done", done_total - bdone, 0);

    // clean frame afterwards; writes to centre coef and bias while busy must be dropped
    load_kernel(1, 0, 0);
    run_frame(1'b0, 1'b1);
    check_frame("t6_after", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
